// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry, named register
// indices, default reset constants and the write-enable decoder.
package mips_pkg;

  localparam int N_REGS    = 32;
  localparam int REG_IDX_W = 5;

  // Register index type, shared with control and hazard logic.
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_GP   = 5'd28;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

  localparam logic [31:0] DEFAULT_SP_RESET = 32'h7FFF_EFFC;
  localparam logic [31:0] DEFAULT_GP_RESET = 32'h1000_8000;

  // One-hot write enable for the implemented cells 1..31; index 0 has no
  // storage, so it never gets an enable bit.
  function automatic logic [N_REGS-1:1] decode_write_enable(input reg_idx_t idx,
                                                            input logic     en);
    logic [N_REGS-1:1] onehot;
    onehot = {(N_REGS-1){1'b0}};
    for (int i = 1; i < N_REGS; i++) begin
      if (en && (idx == reg_idx_t'(i))) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/register_cell.sv
// One N_BITS-wide register with a load enable and a synchronous,
// active-high reset to a per-instance value.
module register_cell #(
  parameter int                N_BITS      = 32,
  parameter logic [N_BITS-1:0] RESET_VALUE = {N_BITS{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_BITS-1:0] d,
  output logic [N_BITS-1:0] q
);

  logic [N_BITS-1:0] data_d;
  logic [N_BITS-1:0] data_q;

  // Next value: load d when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (enable) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // State register; reset overrides any load in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_file.sv
// 32 x N_BITS MIPS general-purpose register file: two combinational read
// ports, one synchronous write port, hardwired zero register, configurable
// $gp/$sp reset values and optional same-cycle write-through bypass.
module register_file
  import mips_pkg::*;
#(
  parameter int                N_BITS        = 32,
  parameter logic [N_BITS-1:0] SP_RESET      = DEFAULT_SP_RESET,
  parameter logic [N_BITS-1:0] GP_RESET      = DEFAULT_GP_RESET,
  parameter int                WRITE_THROUGH = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [N_BITS-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [N_BITS-1:0] ReadData1,
  output logic [N_BITS-1:0] ReadData2
);

  logic [N_REGS-1:1]             wr_en_s;
  logic [N_REGS-1:0][N_BITS-1:0] regs_s;
  logic                          bypass_ok_s;
  logic [N_BITS-1:0]             rd1_s;
  logic [N_BITS-1:0]             rd2_s;

  // Reset priority is enforced inside each cell, so the decoder only needs
  // RegWrite and the index.
  assign wr_en_s = decode_write_enable(WriteRegister, RegWrite);

  // Entry 0 has no storage: it always reads as zero.
  assign regs_s[0] = {N_BITS{1'b0}};

  for (genvar g = 1; g < N_REGS; g++) begin : g_cell
    localparam logic [N_BITS-1:0] CELL_RESET =
      (g == int'(REG_GP)) ? GP_RESET :
      (g == int'(REG_SP)) ? SP_RESET : {N_BITS{1'b0}};

    register_cell #(
      .N_BITS      (N_BITS),
      .RESET_VALUE (CELL_RESET)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .enable (wr_en_s[g]),
      .d      (WriteData),
      .q      (regs_s[g])
    );
  end

  // A forwardable write exists this cycle: bypass enabled, writing, not in
  // reset, and not targeting the zero register.
  always_comb begin
    bypass_ok_s = 1'b0;
    if ((WRITE_THROUGH != 0) && RegWrite && !reset && (WriteRegister != REG_ZERO)) begin
      bypass_ok_s = 1'b1;
    end else begin
      bypass_ok_s = 1'b0;
    end
  end

  // Read port 1: stored value, or the in-flight write data on an index match.
  always_comb begin
    rd1_s = regs_s[ReadRegister1];
    if (bypass_ok_s && (WriteRegister == ReadRegister1)) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = regs_s[ReadRegister1];
    end
  end

  // Read port 2: independent of port 1, same forwarding rule.
  always_comb begin
    rd2_s = regs_s[ReadRegister2];
    if (bypass_ok_s && (WriteRegister == ReadRegister2)) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = regs_s[ReadRegister2];
    end
  end

  assign ReadData1 = rd1_s;
  assign ReadData2 = rd2_s;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a write-through and a plain
// instance share every input and are compared against an array model.
module tb_register_file;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] rd1_wt0, rd2_wt0, rd1_wt1, rd2_wt1;

  int n_total;
  int n_pass;

  logic [31:0] model [32];

  register_file #(.N_BITS(32), .WRITE_THROUGH(0)) u_dut0 (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_wt0), .ReadData2(rd2_wt0)
  );

  register_file #(.N_BITS(32), .WRITE_THROUGH(1)) u_dut1 (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_wt1), .ReadData2(rd2_wt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and apply the architectural update rule to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[28] = 32'h1000_8000;
      model[29] = 32'h7FFF_EFFC;
    end else if (RegWrite && (WriteRegister != 5'd0)) begin
      model[WriteRegister] = WriteData;
    end
    #1;
  endtask

  // Expected read value given current inputs; wt selects write-through.
  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit wt);
    if (idx == 5'd0) return 32'h0;
    if (wt && RegWrite && !reset && (WriteRegister == idx)) return WriteData;
    return model[idx];
  endfunction

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 32'h0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      exp = (i == 28) ? 32'h1000_8000 : (i == 29) ? 32'h7FFF_EFFC : 32'h0;
      n_total++;
      if (rd1_wt0 !== exp || rd1_wt1 !== exp)
        $display("FAIL reset_rd1 idx=%0d got wt0=%h wt1=%h exp=%h", i, rd1_wt0, rd1_wt1, exp);
      else n_pass++;
      exp = (31 - i == 28) ? 32'h1000_8000 : (31 - i == 29) ? 32'h7FFF_EFFC : 32'h0;
      n_total++;
      if (rd2_wt0 !== exp || rd2_wt1 !== exp)
        $display("FAIL reset_rd2 idx=%0d got wt0=%h wt1=%h exp=%h", 31 - i, rd2_wt0, rd2_wt1, exp);
      else n_pass++;
    end
  endtask

  task automatic test_basic_write();
    RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'hDEAD_BEEF;
    tick();
    RegWrite = 1'b0;
    ReadRegister1 = 5'd8; ReadRegister2 = 5'd8;
    #1;
    n_total++;
    if (rd1_wt0 !== 32'hDEAD_BEEF || rd2_wt0 !== 32'hDEAD_BEEF ||
        rd1_wt1 !== 32'hDEAD_BEEF || rd2_wt1 !== 32'hDEAD_BEEF)
      $display("FAIL basic_write got %h %h %h %h exp DEADBEEF", rd1_wt0, rd2_wt0, rd1_wt1, rd2_wt1);
    else n_pass++;
    ReadRegister1 = 5'd9;
    #1;
    n_total++;
    if (rd1_wt0 !== 32'h0 || rd1_wt1 !== 32'h0)
      $display("FAIL basic_neighbour got %h %h exp 0", rd1_wt0, rd1_wt1);
    else n_pass++;
  endtask

  task automatic test_reg0();
    RegWrite = 1'b1; WriteRegister = REG_ZERO; WriteData = 32'hFFFF_FFFF;
    ReadRegister1 = REG_ZERO; ReadRegister2 = REG_ZERO;
    #1;
    n_total++;
    if (rd1_wt1 !== 32'h0 || rd2_wt1 !== 32'h0 || rd1_wt0 !== 32'h0 || rd2_wt0 !== 32'h0)
      $display("FAIL reg0_same_cycle got %h %h %h %h exp 0", rd1_wt0, rd2_wt0, rd1_wt1, rd2_wt1);
    else n_pass++;
    tick();
    RegWrite = 1'b0;
    #1;
    n_total++;
    if (rd1_wt1 !== 32'h0 || rd2_wt1 !== 32'h0 || rd1_wt0 !== 32'h0 || rd2_wt0 !== 32'h0)
      $display("FAIL reg0_next_cycle got %h %h %h %h exp 0", rd1_wt0, rd2_wt0, rd1_wt1, rd2_wt1);
    else n_pass++;
  endtask

  task automatic test_we_gating();
    RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 32'h1234_5678;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
    tick();
    n_total++;
    if (rd1_wt0 !== 32'h0 || rd1_wt1 !== 32'h0)
      $display("FAIL we_gated got %h %h exp 0", rd1_wt0, rd1_wt1);
    else n_pass++;
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    #1;
    n_total++;
    if (rd1_wt0 !== 32'h1234_5678 || rd2_wt1 !== 32'h1234_5678)
      $display("FAIL we_enabled got %h %h exp 12345678", rd1_wt0, rd2_wt1);
    else n_pass++;
  endtask

  task automatic test_bypass();
    ReadRegister1 = 5'd10; ReadRegister2 = 5'd10;
    RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'hA5A5_A5A5;
    #1;
    n_total++;
    if (rd1_wt0 !== 32'h0 || rd2_wt0 !== 32'h0)
      $display("FAIL bypass_wt0_write_cycle got %h %h exp 0", rd1_wt0, rd2_wt0);
    else n_pass++;
    n_total++;
    if (rd1_wt1 !== 32'hA5A5_A5A5 || rd2_wt1 !== 32'hA5A5_A5A5)
      $display("FAIL bypass_wt1_write_cycle got %h %h exp A5A5A5A5", rd1_wt1, rd2_wt1);
    else n_pass++;
    tick();
    RegWrite = 1'b0;
    #1;
    n_total++;
    if (rd1_wt0 !== 32'hA5A5_A5A5 || rd2_wt0 !== 32'hA5A5_A5A5 ||
        rd1_wt1 !== 32'hA5A5_A5A5 || rd2_wt1 !== 32'hA5A5_A5A5)
      $display("FAIL bypass_after_edge got %h %h %h %h exp A5A5A5A5", rd1_wt0, rd2_wt0, rd1_wt1, rd2_wt1);
    else n_pass++;
  endtask

  task automatic test_reset_collision();
    RegWrite = 1'b1; WriteRegister = REG_SP; WriteData = 32'h0000_0100;
    tick();
    ReadRegister1 = REG_SP; ReadRegister2 = 5'd8;
    reset = 1'b1; WriteData = 32'h0000_0200;
    #1;
    n_total++;
    if (rd1_wt0 !== 32'h0000_0100 || rd1_wt1 !== 32'h0000_0100)
      $display("FAIL collision_pre_edge got %h %h exp 00000100", rd1_wt0, rd1_wt1);
    else n_pass++;
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    #1;
    n_total++;
    if (rd1_wt0 !== 32'h7FFF_EFFC || rd1_wt1 !== 32'h7FFF_EFFC)
      $display("FAIL collision_sp got %h %h exp 7FFFEFFC", rd1_wt0, rd1_wt1);
    else n_pass++;
    n_total++;
    if (rd2_wt0 !== 32'h0 || rd2_wt1 !== 32'h0)
      $display("FAIL collision_reg8_cleared got %h %h exp 0", rd2_wt0, rd2_wt1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] pick [6];
    pick[0] = REG_ZERO; pick[1] = REG_GP; pick[2] = REG_SP;
    pick[3] = REG_RA;   pick[4] = 5'd1;   pick[5] = 5'd30;
    for (int n = 0; n < 300; n++) begin
      reset         = ($urandom_range(0, 40) == 0);
      RegWrite      = $urandom_range(0, 1) == 1;
      WriteRegister = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      ReadRegister1 = ($urandom_range(0, 2) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 2) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
      #1;
      n_total++;
      if (rd1_wt0 !== exp_read(ReadRegister1, 1'b0) || rd2_wt0 !== exp_read(ReadRegister2, 1'b0))
        $display("FAIL random_wt0 it=%0d r1=%0d r2=%0d got %h %h exp %h %h", n, ReadRegister1, ReadRegister2,
                 rd1_wt0, rd2_wt0, exp_read(ReadRegister1, 1'b0), exp_read(ReadRegister2, 1'b0));
      else n_pass++;
      n_total++;
      if (rd1_wt1 !== exp_read(ReadRegister1, 1'b1) || rd2_wt1 !== exp_read(ReadRegister2, 1'b1))
        $display("FAIL random_wt1 it=%0d r1=%0d r2=%0d got %h %h exp %h %h", n, ReadRegister1, ReadRegister2,
                 rd1_wt1, rd2_wt1, exp_read(ReadRegister1, 1'b1), exp_read(ReadRegister2, 1'b1));
      else n_pass++;
      tick();
    end
    reset = 1'b0; RegWrite = 1'b0;
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 32'h0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #2;
    test_reset();
    test_basic_write();
    test_reg0();
    test_we_gating();
    test_bypass();
    test_reset_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file. It sits directly upstream of the ALU and drives its A and B operands (ReadData1 to A, ReadData2 to B via the ALUSrc mux).
- Two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero; $sp and $gp take configurable reset values.
- Optional write-through bypass so the block can also serve a pipelined datapath.

Parameters:
- N_BITS, 32, data width of every register.
- SP_RESET, 32'h7FFF_EFFC, reset value of register 29 ($sp).
- GP_RESET, 32'h1000_8000, reset value of register 28 ($gp).
- WRITE_THROUGH, 0, when 1 a same-cycle write to the addressed register is forwarded to the read port.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable, sampled at rising edge of clk.
- WriteRegister  input  5  destination register index.
- WriteData  input  N_BITS  data to write.
- ReadRegister1  input  5  index for port 1 (rs).
- ReadRegister2  input  5  index for port 2 (rt).
- ReadData1  output  N_BITS  contents of ReadRegister1, feeds ALU A.
- ReadData2  output  N_BITS  contents of ReadRegister2, feeds ALU B / store data.

Behaviour:
- Reset (clk rising edge with reset=1):
  - All registers clear to 0, except reg28 = GP_RESET and reg29 = SP_RESET.
  - A write requested in the same cycle is discarded, because reset has priority.
  - Reset asserted mid-program overrides any pending write. The register contents are the reset image on the next cycle.
- Write:
  - On a rising edge with reset=0 and RegWrite=1, reg[WriteRegister] <= WriteData.
  - The value becomes visible on the read ports in the cycle after the edge.
  - RegWrite=0 leaves every register unchanged.
- Register 0:
  - Writes to index 0 are ignored.
  - Reads of index 0 always return 0, including with WRITE_THROUGH=1 and RegWrite=1, WriteRegister=0.
- Read:
  - Purely combinational, with zero-cycle latency from ReadRegisterN to ReadDataN.
  - Outputs are not registered.
  - ReadData values right after reset reflect the reset image (reg0=0, reg28=GP_RESET, reg29=SP_RESET, all others 0).
- WRITE_THROUGH=0: ReadDataN shows the stored value. A same-cycle write to the same index is seen only after the edge. This is the mode for the single-cycle datapath; it avoids a combinational loop ALU -> WriteData -> ReadData -> ALU.
- WRITE_THROUGH=1: if RegWrite=1 and reset=0 and WriteRegister == ReadRegisterN and WriteRegister != 0, then ReadDataN = WriteData. Otherwise ReadDataN is the stored value. Both ports bypass independently, and both may bypass at once when they address the same register.
- Both read ports may address the same register, and the two ports return identical data.
- No undefined (X) output for any 5-bit index, because all 32 entries are implemented.

Decomposition:
- Shared package mips_pkg:
  - N_REGS=32 and REG_IDX_W=5.
  - Named register indices: ZERO=0, GP=28, SP=29, RA=31.
  - Default SP/GP reset constants.
  - A register-index typedef, which is reused by the control and hazard logic.
- Sub-module register_cell: one N_BITS synchronous register with parameter RESET_VALUE, inputs clk, reset, enable and d, and output q.
  - register_file instantiates 31 cells (indices 1..31) from a generate loop, with a one-hot enable decoded from WriteRegister & RegWrite.
  - Two 32:1 read multiplexers plus optional bypass compare complete the block.

Test Plan:
- Reset check: assert reset 1 cycle, then sweep ReadRegister1 over 0..31. Require reg0..27 = 0, reg28 = 32'h1000_8000, reg29 = 32'h7FFF_EFFC, reg30..31 = 0.
- Basic write/read: write 32'hDEAD_BEEF to reg8 (RegWrite=1), then read reg8 on both ports next cycle. Require 32'hDEAD_BEEF on both ports; reg9 is still 0.
- Register 0 protection: write 32'hFFFF_FFFF to reg0 with WRITE_THROUGH=1, then read reg0 in the same cycle and the next. Require 0 in both.
- Write-enable gating: with RegWrite=0, drive WriteRegister=5, WriteData=32'h1234_5678 and clock. Require reg5 = 0. Then raise RegWrite and clock; require reg5 = 32'h1234_5678.
- Bypass timing: hold ReadRegister1=ReadRegister2=10 and write 32'hA5A5_A5A5 to reg10.
  - WRITE_THROUGH=0: require the old value in the write cycle and 32'hA5A5_A5A5 after the edge.
  - WRITE_THROUGH=1: require 32'hA5A5_A5A5 combinationally in the write cycle.
- Reset vs write collision: reg29 holds 32'h0000_0100. Assert reset with RegWrite=1, WriteRegister=29, WriteData=32'h0000_0200. Require reg29 = 32'h7FFF_EFFC after the edge, with the write discarded.
